clk_ce_divider: RTL

- Multi-channel, runtime-programmable clock-enable generator for SoC tops.
- Generalises the fixed divide-by-2 BUFGCE enable toggle into N independent channels with per-channel divisors.
- Each ce_out bit drives a BUFGCE CE pin or a fabric clock enable, giving divided clock domains.
- Supports glitch-free divisor changes at period boundaries, per-channel enable, global realignment and divisor readback.

---
 rtl/clk_ce_divider_if.sv | 25 ++
 rtl/clk_ce_divider.sv | 87 ++++++++
 2 files changed

// File: rtl/clk_ce_divider_if.sv
// Control and output bundle for the clock-enable divider.
// The bench or SoC top drives it through master; the divider consumes it through slave.
interface clk_ce_divider_if #(
  parameter int CHANNELS  = 4,
  parameter int DIV_WIDTH = 8,
  parameter int RD_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic [CHANNELS-1:0]  ch_en;
  logic [CHANNELS-1:0]  div_wr;
  logic [DIV_WIDTH-1:0] div_wdata;
  logic                 realign;
  logic [RD_W-1:0]      rd_sel;
  logic [DIV_WIDTH-1:0] rd_div;
  logic [CHANNELS-1:0]  ce_out;

  modport master (
    output ch_en, div_wr, div_wdata, realign, rd_sel,
    input  rd_div, ce_out
  );

  modport slave (
    input  ch_en, div_wr, div_wdata, realign, rd_sel,
    output rd_div, ce_out
  );
endinterface

// File: rtl/clk_ce_divider.sv
// N-channel programmable clock-enable generator: one registered ce pulse every d cycles per channel.
// First pulse 1 cycle after enable; divisor changes land only at period boundaries; no backpressure.
module clk_ce_divider #(
  parameter int CHANNELS    = 4,
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic               clk,
  input  logic               rst,
  clk_ce_divider_if.slave    bus
);
  localparam logic [DIV_WIDTH-1:0] DEF_DIV = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] cnt_q     [CHANNELS];
  logic [DIV_WIDTH-1:0] cnt_d     [CHANNELS];
  logic [DIV_WIDTH-1:0] div_act_q [CHANNELS];
  logic [DIV_WIDTH-1:0] div_act_d [CHANNELS];
  logic [DIV_WIDTH-1:0] pend_q    [CHANNELS];
  logic [DIV_WIDTH-1:0] pend_d    [CHANNELS];
  logic [DIV_WIDTH-1:0] reload    [CHANNELS];
  logic [DIV_WIDTH-1:0] reload_eff[CHANNELS];
  logic [CHANNELS-1:0]  pend_vld_q, pend_vld_d;
  logic [CHANNELS-1:0]  ce_q, ce_d;
  logic [DIV_WIDTH-1:0] rd_div_q, rd_div_d;

  // A same-cycle write beats the pending value, which beats the active one.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      reload[i]     = bus.div_wr[i] ? bus.div_wdata
                    : (pend_vld_q[i] ? pend_q[i] : div_act_q[i]);
      reload_eff[i] = (reload[i] == '0) ? ONE : reload[i];
    end
  end

  always_comb begin
    pend_vld_d = pend_vld_q;
    ce_d       = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i]     = cnt_q[i];
      div_act_d[i] = div_act_q[i];
      pend_d[i]    = pend_q[i];
      if (bus.realign || !bus.ch_en[i]) begin
        cnt_d[i]      = '0;
        div_act_d[i]  = reload[i];
        pend_vld_d[i] = 1'b0;
      end else if (cnt_q[i] == '0) begin
        ce_d[i]       = 1'b1;
        div_act_d[i]  = reload[i];
        cnt_d[i]      = reload_eff[i] - ONE;
        pend_vld_d[i] = 1'b0;
      end else begin
        cnt_d[i] = cnt_q[i] - ONE;
        if (bus.div_wr[i]) begin
          pend_d[i]     = bus.div_wdata;
          pend_vld_d[i] = 1'b1;
        end
      end
    end
    rd_div_d = (32'(bus.rd_sel) < CHANNELS) ? div_act_q[bus.rd_sel] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]     <= '0;
        div_act_q[i] <= DEF_DIV;
        pend_q[i]    <= '0;
      end
      pend_vld_q <= '0;
      ce_q       <= '0;
      rd_div_q   <= DEF_DIV;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]     <= cnt_d[i];
        div_act_q[i] <= div_act_d[i];
        pend_q[i]    <= pend_d[i];
      end
      pend_vld_q <= pend_vld_d;
      ce_q       <= ce_d;
      rd_div_q   <= rd_div_d;
    end
  end

  assign bus.ce_out = ce_q;
  assign bus.rd_div = rd_div_q;
endmodule
